// File: rtl/fifo_rd_stream.sv
// Read-side stream adapter: turns a FIFO read port into a valid/ready stream via a 2-entry head/skid buffer.
// Define FIFO_RD_STREAM_CNT_EN to add the saturating rd_word_cnt delivered-word counter.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  input  logic                  flush,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
`ifdef FIFO_RD_STREAM_CNT_EN
  ,
  output logic [15:0]           rd_word_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  push;
  logic                  xfer;

  // Pop only when the skid slot is guaranteed free; gating with rrst_n keeps rinc low during reset.
  assign push      = rrst_n & ~rempty & (state_q != ST_TWO) & ~flush;
  assign rinc      = push;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = head_q;
  assign xfer      = out_valid & out_ready;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d = ST_ONE;
            head_d  = rdata;
          end
        end
        ST_ONE: begin
          if (push && xfer) begin
            head_d = rdata;
          end else if (push) begin
            state_d = ST_TWO;
            skid_d  = rdata;
          end else if (xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (xfer) begin
            state_d = ST_ONE;
            head_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

`ifdef FIFO_RD_STREAM_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // A flushed transfer never reaches the consumer, so it is not counted.
  always_comb begin
    cnt_d = cnt_q;
    if (xfer && !flush && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign rd_word_cnt = cnt_q;
`endif

endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of the FIFO word and of the output data.
REQ-002 rclk  input  1  read-domain clock; all state updates on its rising edge.
REQ-003 rrst_n  input  1  reset, asynchronous, active-low.
REQ-004 rempty  input  1  FIFO empty flag from the read-pointer stage.
REQ-005 rdata  input  DATA_WIDTH  FIFO word at the current read address, combinationally valid when rempty=0.
REQ-006 rinc  output  1  pop request to the read-pointer stage; one pop per cycle it is high.
REQ-007 flush  input  1  synchronous clear of buffered words.
REQ-008 out_ready  input  1  downstream accepts out_data this cycle.
REQ-009 out_valid  output  1  out_data holds a valid word.
REQ-010 out_data  output  DATA_WIDTH  head word of the output buffer.
REQ-011 rd_word_cnt  output  16  delivered-word count; present only with FIFO_RD_STREAM_CNT_EN.

Function
REQ-012 Two-entry output buffer (head, skid) with occupancy state EMPTY(0), ONE(1), TWO(2).
REQ-013 rinc combinational: rinc = ~rempty & (state != TWO) & ~flush.
REQ-014 When rinc=1, rdata is written into the buffer on the same rising edge; it appears on out_data no earlier than one cycle after the rinc cycle.
REQ-015 out_valid = (state != EMPTY), registered-state derived, no combinational path from rempty or rdata.
REQ-016 A transfer occurs when out_valid & out_ready; out_data and out_valid are held stable while out_valid=1 and out_ready=0.
REQ-017 Transitions: EMPTY+push -> ONE; ONE+push, no transfer -> TWO; ONE+push+transfer -> ONE with the new word as head; ONE+transfer, no push -> EMPTY; TWO+transfer -> ONE with the skid word promoted to head; otherwise no change.
REQ-018 In TWO, rinc is forced low even when out_ready=1; no push and pop in the same cycle at TWO.
REQ-019 Sustained throughput is one word per cycle while rempty=0 and out_ready=1 (state holds at ONE).
REQ-020 Words are delivered in FIFO order; no word is dropped or duplicated.
REQ-021 flush=1 forces state to EMPTY on the next edge, discards buffered words, suppresses rinc that cycle, and wins over a simultaneous transfer; the transfer is not counted.
REQ-022 rempty rising while a push is pending has no effect beyond suppressing rinc; buffered words are kept.

Reset
REQ-023 rrst_n low asynchronously sets state EMPTY, out_valid=0, out_data=0, head/skid=0, and rd_word_cnt=0.
REQ-024 rinc is 0 throughout reset regardless of rempty.
REQ-025 Reset mid-transfer discards all buffered words; operation resumes from EMPTY on the first edge after release.

Configuration
REQ-026 Macro FIFO_RD_STREAM_CNT_EN, when defined, adds rd_word_cnt, incremented by 1 per transfer and saturating at 16'hFFFF, not cleared by flush.
REQ-027 Without FIFO_RD_STREAM_CNT_EN, the rd_word_cnt port and counter logic are absent; all other behaviour is identical.

Verification
REQ-028 Reset, rempty=0, rdata=8'hA5, out_ready=0 -> rinc high on cycles 1 and 2 only, out_valid=1 with out_data=8'hA5 from cycle 2, state TWO, rinc low thereafter.
REQ-029 Stream 8'h01..8'h10 with out_ready=1 held -> 16 words out in order, one per cycle after the first-word latency of 1, state never reaches TWO.
REQ-030 Buffer TWO holding 8'h11 and 8'h22, out_ready toggled 1/0, rempty=1 -> 8'h11 then 8'h22 delivered, out_valid drops after the second transfer, no rinc.
REQ-031 Buffer TWO, flush=1 with out_ready=1 and rempty=0 -> rinc=0 that cycle, out_valid=0 next cycle, rd_word_cnt unchanged.
REQ-032 rrst_n pulled low mid-stream between clock edges -> out_valid and rinc go 0 immediately, and after release the next word out is the FIFO's current head.
REQ-033 With FIFO_RD_STREAM_CNT_EN, preload the counter to 16'hFFFE and perform 3 transfers -> rd_word_cnt=16'hFFFF and stays there.
